// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-back, write-allocate data cache (8 frames x 2 words)
// Ports:
//   CLK, nRST                      clock and asynchronous active-low reset
//   halt                           datapath halted; write back all dirty frames, then raise flushed
//   dmemREN, dmemWEN, datomic      datapath load/store request; datomic marks LL/SC
//   dmemaddr, dmemstore            request word address and store data
//   dhit, dmemload, flushed        request completion, load data / SC result, flush done
//   dREN, dWEN, daddr, dstore      memory-side request
//   dwait, dload                   memory busy and read data
// Optional feature: define LLSC_EN to keep a link register for LL/SC.
module dcache_responder (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    typedef enum logic [2:0] {IDLE, WB0, WB1, LD0, LD1, FLUSH0, FLUSH1, FLUSHED} state_t;
    state_t      state, next_state;
    logic [7:0]  valid, dirty;
    logic [25:0] tags [8];
    logic [31:0] data [8][2];
    logic [2:0]  cnt;
    logic [25:0] req_tag;
    logic [2:0]  idx;
    logic        word, req, hit, miss, wr_hit, flush_wb, xfer, last, sc_fail, sc_ok;
    logic        unused;

    assign req_tag  = dmemaddr[31:6];
    assign idx      = dmemaddr[5:3];
    assign word     = dmemaddr[2];
    assign xfer     = !dwait;
    assign last     = cnt == 3'd7;
    assign flush_wb = valid[cnt] && dirty[cnt];
    // halt outranks any request; nRST gating keeps dhit at its reset value while reset is held
    assign req      = nRST && state == IDLE && !halt && (dmemREN || dmemWEN);
    assign hit      = req && valid[idx] && tags[idx] == req_tag;
    assign miss     = req && !hit && !sc_fail;
    // both enables high is treated as a store
    assign wr_hit   = hit && dmemWEN && !sc_fail;
    assign dhit     = hit || sc_fail;
    assign dmemload = (sc_fail || !hit) ? 32'd0 : dmemWEN ? {31'd0, sc_ok} : data[idx][word];

`ifdef LLSC_EN
    logic        link_valid;
    logic [29:0] link_addr;
    logic        link_match;
    assign link_match = link_valid && link_addr == dmemaddr[31:2];
    // a failed SC completes at once without touching the cache or memory
    assign sc_fail    = req && dmemWEN && datomic && !link_match;
    assign sc_ok      = hit && dmemWEN && datomic && link_match;
    assign unused     = &{1'b0, dmemaddr[1:0]};
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (wr_hit && link_match) begin
            link_valid <= 1'b0;
        end else if (hit && !dmemWEN && datomic) begin
            link_valid <= 1'b1;
            link_addr  <= dmemaddr[31:2];
        end
`else
    assign sc_fail = 1'b0;
    assign sc_ok   = 1'b0;
    assign unused  = &{1'b0, datomic, dmemaddr[1:0]};
`endif

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) state <= IDLE;
        else       state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = halt ? FLUSH0 : miss ? ((valid[idx] && dirty[idx]) ? WB0 : LD0) : IDLE;
            WB0:     next_state = xfer ? WB1 : WB0;
            WB1:     next_state = xfer ? LD0 : WB1;
            LD0:     next_state = xfer ? LD1 : LD0;
            LD1:     next_state = xfer ? IDLE : LD1;
            // clean frames are skipped without a memory cycle
            FLUSH0:  next_state = flush_wb ? (xfer ? FLUSH1 : FLUSH0) : (last ? FLUSHED : FLUSH0);
            FLUSH1:  next_state = xfer ? (last ? FLUSHED : FLUSH0) : FLUSH1;
            default: next_state = FLUSHED;
        endcase
    end

    always_comb begin
        dREN    = 1'b0;
        dWEN    = 1'b0;
        daddr   = '0;
        dstore  = '0;
        flushed = state == FLUSHED;
        case (state)
            WB0, WB1: begin
                dWEN   = 1'b1;
                daddr  = {tags[idx], idx, state == WB1, 2'b00};
                dstore = data[idx][state == WB1];
            end
            LD0, LD1: begin
                dREN  = 1'b1;
                daddr = {dmemaddr[31:3], state == LD1, 2'b00};
            end
            FLUSH0, FLUSH1: begin
                dWEN   = flush_wb;
                daddr  = flush_wb ? {tags[cnt], cnt, state == FLUSH1, 2'b00} : 32'd0;
                dstore = flush_wb ? data[cnt][state == FLUSH1] : 32'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            valid <= '0;
            dirty <= '0;
            cnt   <= '0;
            for (int i = 0; i < 8; i++) tags[i] <= '0;
        end else begin
            if (wr_hit) dirty[idx] <= 1'b1;
            if (state == LD1 && xfer) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
                tags[idx]  <= req_tag;
            end
            if (state == IDLE) cnt <= '0;
            if ((state == FLUSH0 && !flush_wb) || (state == FLUSH1 && xfer)) begin
                dirty[cnt] <= 1'b0;
                cnt        <= cnt + 3'd1;
            end
        end

    always_ff @(posedge CLK) begin
        if (wr_hit) data[idx][word] <= dmemstore;
        if ((state == LD0 || state == LD1) && xfer) data[idx][state == LD1] <= dload;
    end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: self-checking bench for dcache_responder (honours LLSC_EN when defined)
module tb_dcache_responder;
    logic        CLK = 1'b0;
    logic        nRST, halt, dmemREN, dmemWEN, datomic, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    dcache_responder dut (
        .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .datomic(datomic), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
        .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .dwait(dwait), .dload(dload)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [1024];
    logic [31:0] golden [1024];
    logic [31:0] wr_log[$], wd_log[$], rd_log[$];
    int          checks = 0, errors = 0, proto_err = 0, dw_mode = 0;

    assign dload = mem[daddr[11:2]];

    // memory: commits a word late in the cycle, while all DUT outputs are settled
    initial forever begin
        @(negedge CLK);
        #3;
        if (dREN && dWEN) proto_err++;
        if (nRST && dWEN && !dwait) begin
            mem[daddr[11:2]] = dstore;
            wr_log.push_back(daddr);
            wd_log.push_back(dstore);
        end
        if (nRST && dREN && !dwait) rd_log.push_back(daddr);
    end

    // dwait source: 0 = driven by the test, 1 = random, 2 = alternating
    initial forever begin
        @(posedge CLK);
        #1;
        if (dw_mode == 1) dwait = ($urandom_range(0, 2) == 0);
        else if (dw_mode == 2) dwait = ~dwait;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mem_init();
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    endtask

    task automatic do_reset();
        nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
        dmemaddr = '0; dmemstore = '0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    // issues one request at posedge+1 and returns the result and the cycles spent before dhit
    task automatic do_req(input logic r, input logic w, input logic a, input logic [31:0] ad,
                          input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        dmemREN = r; dmemWEN = w; datomic = a; dmemaddr = ad; dmemstore = wd;
        rd = '0; cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (dhit) begin
                rd = dmemload;
                break;
            end
            cyc++;
        end
        if (cyc >= 300) begin
            errors++;
            $display("FAIL timeout waiting for dhit at addr %0h", ad);
        end
        @(posedge CLK);
        #1 dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    endtask

    task automatic wait_flushed();
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge CLK);
            if (flushed) break;
        end
        check("flush completes", {63'd0, flushed}, 64'd1);
    endtask

    typedef struct {
        logic        r, w;
        logic [31:0] addr, wdata;
        logic        imm;
        logic [31:0] load;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] rd;
    int          cyc, n;
    logic [25:0] mtag [8];
    logic [7:0]  mvalid;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h300, 32'h0,        1'b0, 32'hC0DE00C0};
        tbl[1]  = '{1'b1, 1'b0, 32'h304, 32'h0,        1'b1, 32'hC0DE00C1};
        tbl[2]  = '{1'b0, 1'b1, 32'h304, 32'h11112222, 1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h304, 32'h0,        1'b1, 32'h11112222};
        tbl[4]  = '{1'b1, 1'b0, 32'h340, 32'h0,        1'b0, 32'hC0DE00D0};
        tbl[5]  = '{1'b1, 1'b0, 32'h304, 32'h0,        1'b0, 32'h11112222};
        tbl[6]  = '{1'b1, 1'b0, 32'h308, 32'h0,        1'b0, 32'hC0DE00C2};
        tbl[7]  = '{1'b0, 1'b1, 32'h30C, 32'hDEADBEEF, 1'b1, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'h30C, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[9]  = '{1'b1, 1'b1, 32'h308, 32'h55,       1'b1, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h308, 32'h0,        1'b1, 32'h55};
        tbl[11] = '{1'b1, 1'b0, 32'h303, 32'h0,        1'b1, 32'hC0DE00C0};

        nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
        dmemaddr = '0; dmemstore = '0; dwait = 1'b0;
        mem_init();
        #3;
        check("reset flags", {60'd0, dhit, flushed, dREN, dWEN}, 64'd0);
        check("reset dmemload", {32'd0, dmemload}, 64'd0);
        check("reset daddr", {32'd0, daddr}, 64'd0);
        check("reset dstore", {32'd0, dstore}, 64'd0);
        @(posedge CLK);
        #1;

        // table of requests
        do_reset(); mem_init(); dw_mode = 1;
        for (int i = 0; i < 12; i++) begin
            do_req(tbl[i].r, tbl[i].w, 1'b0, tbl[i].addr, tbl[i].wdata, rd, cyc);
            check($sformatf("vec%0d hit-now", i), {63'd0, cyc == 0}, {63'd0, tbl[i].imm});
            check($sformatf("vec%0d load", i), {32'd0, rd}, {32'd0, tbl[i].load});
        end

        // cold load with two-cycle memory words
        do_reset(); mem_init(); mem[32'h40] = 32'hAAAA0000; mem[32'h41] = 32'hBBBB0001;
        dw_mode = 2; rd_log.delete();
        do_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, rd, cyc);
        check("cold lw data", {32'd0, rd}, 64'hAAAA0000);
        check("cold lw reads", rd_log.size(), 2);
        check("cold lw addr0", rd_log.size() > 0 ? rd_log[0] : 32'hFFFFFFFF, 32'h100);
        check("cold lw addr1", rd_log.size() > 1 ? rd_log[1] : 32'hFFFFFFFF, 32'h104);
        do_req(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, rd, cyc);
        check("lw 104 hit-now", cyc, 0);
        check("lw 104 data", {32'd0, rd}, 64'hBBBB0001);

        // dirty eviction
        wr_log.delete(); wd_log.delete(); rd_log.delete();
        do_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h12345678, rd, cyc);
        check("sw hit-now", cyc, 0);
        do_req(1'b1, 1'b0, 1'b0, 32'h140, 32'h0, rd, cyc);
        check("evict wr count", wr_log.size(), 2);
        check("evict wr addr0", wr_log.size() > 0 ? wr_log[0] : 32'hFFFFFFFF, 32'h100);
        check("evict wr data0", wd_log.size() > 0 ? wd_log[0] : 32'hFFFFFFFF, 32'h12345678);
        check("evict wr addr1", wr_log.size() > 1 ? wr_log[1] : 32'hFFFFFFFF, 32'h104);
        check("evict rd addr0", rd_log.size() > 0 ? rd_log[0] : 32'hFFFFFFFF, 32'h140);
        check("evict rd addr1", rd_log.size() > 1 ? rd_log[1] : 32'hFFFFFFFF, 32'h144);
        check("evict lw data", {32'd0, rd}, 64'hC0DE0050);

        // memory stall in LD0
        dw_mode = 0; dwait = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h180;
        for (n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (dREN) break;
        end
        check("stall reaches load", {63'd0, dREN}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall cycle %0d", k), {29'd0, dhit, dREN, dWEN, daddr}, {29'd0, 3'b010, 32'h180});
            @(negedge CLK);
        end
        #1 dwait = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (dhit) break;
        end
        check("stall load data", {32'd0, dmemload}, 64'hC0DE0060);
        @(posedge CLK);
        #1 dmemREN = 1'b0;

        // flush of dirty frames 2 and 5
        do_reset(); mem_init(); dw_mode = 1;
        do_req(1'b0, 1'b1, 1'b0, 32'h010, 32'h22220010, rd, cyc);
        do_req(1'b0, 1'b1, 1'b0, 32'h028, 32'h55550028, rd, cyc);
        wr_log.delete();
        halt = 1'b1;
        wait_flushed();
        check("flush wr count", wr_log.size(), 4);
        check("flush wr0", wr_log.size() > 0 ? wr_log[0] : 32'hFFFFFFFF, 32'h010);
        check("flush wr1", wr_log.size() > 1 ? wr_log[1] : 32'hFFFFFFFF, 32'h014);
        check("flush wr2", wr_log.size() > 2 ? wr_log[2] : 32'hFFFFFFFF, 32'h028);
        check("flush wr3", wr_log.size() > 3 ? wr_log[3] : 32'hFFFFFFFF, 32'h02C);
        check("flush mem frame2", {32'd0, mem[4]}, 64'h22220010);
        check("flush mem frame5", {32'd0, mem[10]}, 64'h55550028);
        #1 halt = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h010;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check($sformatf("flushed hold %0d", k), {60'd0, flushed, dhit, dREN, dWEN}, 64'b1000);
        end
        #1 dmemREN = 1'b0;
        @(posedge CLK);
        #1;

`ifdef LLSC_EN
        do_reset(); mem_init(); dw_mode = 1;
        do_req(1'b0, 1'b1, 1'b1, 32'h240, 32'h77, rd, cyc);
        check("sc no link hit-now", cyc, 0);
        check("sc no link result", {32'd0, rd}, 64'd0);
        do_req(1'b1, 1'b0, 1'b0, 32'h240, 32'h0, rd, cyc);
        check("sc no link mem", {32'd0, rd}, 64'hC0DE0090);
        do_req(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, rd, cyc);
        check("ll data", {32'd0, rd}, 64'hC0DE0080);
        do_req(1'b0, 1'b1, 1'b0, 32'h200, 32'h1, rd, cyc);
        do_req(1'b0, 1'b1, 1'b1, 32'h200, 32'h99, rd, cyc);
        check("sc broken hit-now", cyc, 0);
        check("sc broken result", {32'd0, rd}, 64'd0);
        do_req(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, rd, cyc);
        check("sc broken no write", {32'd0, rd}, 64'h1);
        do_req(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, rd, cyc);
        do_req(1'b0, 1'b1, 1'b1, 32'h200, 32'h99, rd, cyc);
        check("sc ok result", {32'd0, rd}, 64'd1);
        do_req(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, rd, cyc);
        check("sc ok written", {32'd0, rd}, 64'h99);
        do_req(1'b0, 1'b1, 1'b1, 32'h200, 32'h77, rd, cyc);
        check("sc after sc result", {32'd0, rd}, 64'd0);
        do_req(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, rd, cyc);
        check("sc after sc no write", {32'd0, rd}, 64'h99);
`else
        do_reset(); mem_init(); dw_mode = 1;
        do_req(1'b0, 1'b1, 1'b1, 32'h200, 32'h99, rd, cyc);
        check("sc as sw result", {32'd0, rd}, 64'd0);
        do_req(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, rd, cyc);
        check("ll as lw data", {32'd0, rd}, 64'h99);
`endif

        // reset during WB1
        do_reset(); mem_init(); dw_mode = 0; dwait = 1'b0;
        do_req(1'b0, 1'b1, 1'b0, 32'h000, 32'h0BADF00D, rd, cyc);
        dwait = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h040;
        for (n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (dWEN) break;
        end
        check("wb0 addr", {31'd0, dWEN, daddr}, {31'd0, 1'b1, 32'h000});
        check("wb0 data", {32'd0, dstore}, 64'h0BADF00D);
        #1 dwait = 1'b0;
        @(posedge CLK);
        #1 dwait = 1'b1;
        @(negedge CLK);
        check("wb1 addr", {31'd0, dWEN, daddr}, {31'd0, 1'b1, 32'h004});
        #1 nRST = 1'b0;
        #1;
        check("midreset flags", {60'd0, dhit, flushed, dREN, dWEN}, 64'd0);
        check("midreset dmemload", {32'd0, dmemload}, 64'd0);
        check("midreset daddr", {32'd0, daddr}, 64'd0);
        check("midreset dstore", {32'd0, dstore}, 64'd0);
        @(posedge CLK);
        #1 dmemREN = 1'b0; dwait = 1'b0; nRST = 1'b1;
        do_req(1'b1, 1'b0, 1'b0, 32'h000, 32'h0, rd, cyc);
        check("post-reset miss", {63'd0, cyc > 0}, 64'd1);
        check("post-reset data", {32'd0, rd}, 64'h0BADF00D);

        // random traffic against a transparent-memory model plus residency per index
        do_reset(); mem_init(); dw_mode = 1;
        for (int i = 0; i < 1024; i++) golden[i] = mem[i];
        mvalid = '0;
        for (int t = 0; t < 300; t++) begin
            int          op, w_idx;
            logic [31:0] ad, wd;
            logic        a, exp_imm;
            op = $urandom_range(0, 3);
            w_idx = $urandom_range(0, 255);
            ad = 32'(w_idx * 4 + $urandom_range(0, 3));
            wd = $urandom;
`ifdef LLSC_EN
            a = 1'b0;
`else
            a = 1'($urandom_range(0, 1));
`endif
            exp_imm = mvalid[ad[5:3]] && mtag[ad[5:3]] == ad[31:6];
            do_req(op != 2, op >= 2, a, ad, wd, rd, cyc);
            check($sformatf("rnd%0d hit-now", t), {63'd0, cyc == 0}, {63'd0, exp_imm});
            if (op < 2) check($sformatf("rnd%0d load", t), {32'd0, rd}, {32'd0, golden[w_idx]});
            else golden[w_idx] = wd;
            mvalid[ad[5:3]] = 1'b1;
            mtag[ad[5:3]] = ad[31:6];
        end
        halt = 1'b1;
        wait_flushed();
        n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== golden[i]) n++;
        check("rnd flush image mismatches", n, 0);
        check("dREN and dWEN never together", proto_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 CLK  in  1  clock; all state on rising edge.
REQ-002 nRST  in  1  asynchronous, active-low reset.
REQ-003 halt  in  1  datapath halted; starts the flush.
REQ-004 dmemREN  in  1  datapath load request (LW/LL).
REQ-005 dmemWEN  in  1  datapath store request (SW/SC).
REQ-006 datomic  in  1  request is LL (with REN) or SC (with WEN).
REQ-007 dmemaddr  in  32  word address; bits [1:0] ignored.
REQ-008 dmemstore  in  32  store data.
REQ-009 dhit  out  1  request completed this cycle.
REQ-010 dmemload  out  32  load data, or SC result.
REQ-011 flushed  out  1  all dirty data written back after halt.
REQ-012 dREN  out  1  memory read request.
REQ-013 dWEN  out  1  memory write request.
REQ-014 daddr  out  32  memory word address.
REQ-015 dstore  out  32  memory write data.
REQ-016 dwait  in  1  memory busy; a word transfers on a cycle where a request is high and dwait is low.
REQ-017 dload  in  32  memory read data, valid when dwait is low.

Function
REQ-018 Organisation: direct-mapped, write-back, write-allocate; 8 frames of 2 words; tag = addr[31:6], index = addr[5:3], word select = addr[2]; each frame has valid, dirty and tag bits.
REQ-019 States: IDLE, WB0, WB1, LD0, LD1, FLUSH0, FLUSH1, FLUSHED.
REQ-020 In IDLE, a hit is: (dmemREN or dmemWEN), frame valid and tag match.
REQ-021 On a hit, dhit goes high combinationally in the same cycle; dhit is never high outside IDLE.
REQ-022 Read hit: dmemload = the selected word.
REQ-023 Write hit: the word is written at the next edge and dirty is set.
REQ-024 On a miss with a dirty frame: IDLE -> WB0 -> WB1, writing word0 then word1 to {stored tag, index, word, 00}; then -> LD0.
REQ-025 On a miss with a clean frame: IDLE -> LD0 directly.
REQ-026 LD0 -> LD1 -> IDLE, reading words 0 and 1 of the requested block.
REQ-027 After LD1: valid=1, dirty=0, tag updated; the request then hits in IDLE.
REQ-028 Each WB/LD state advances only on the cycle where dwait is low; otherwise it holds dREN/dWEN, daddr and dstore stable.
REQ-029 dREN/dWEN are never both high; in IDLE with no miss, dREN=dWEN=0 and daddr=0.
REQ-030 dmemREN and dmemWEN both high is a protocol error; treat it as a write.
REQ-031 halt high in IDLE takes priority over any request: -> FLUSH0 with the 3-bit frame counter at 0.
REQ-032 FLUSH0/FLUSH1 write back word0/word1 of the counted frame if it is valid and dirty; otherwise skip in zero memory cycles.
REQ-033 Flushing clears each frame's dirty bit and increments the counter; after frame 7 -> FLUSHED.
REQ-034 FLUSHED is terminal until reset: flushed=1, dhit=0, no memory requests.
REQ-035 halt rising during a miss: the current WB/LD sequence completes first, then the flush starts from IDLE.

Reset
REQ-036 nRST low, at any time including mid-transaction: all valid/dirty/tag bits, link register and counter clear; state -> IDLE.
REQ-037 Reset values: dhit=0, dmemload=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0.
REQ-038 Data words need no reset.

Configuration
REQ-039 LLSC_EN defined: a link register {valid, addr[31:2]} is kept.
REQ-040 LLSC_EN defined, LL: a read hit sets the link to the address.
REQ-041 LLSC_EN defined, SC with link valid and address match: behaves as a store and returns dmemload=1.
REQ-042 LLSC_EN defined, SC with no link or a mismatch: dhit=1 in the same cycle, no write, no miss service, dmemload=0.
REQ-043 LLSC_EN defined: any completed store (SW or SC) to the linked word clears the link, and a successful SC clears it.
REQ-044 LLSC_EN undefined: datomic is ignored; SC acts as SW and LL acts as LW; no link register is instantiated.

Verification
REQ-045 Cold LW 0x100 with memory word0=0xAAAA0000, word1=0xBBBB0001, dwait low 2 cycles per word -> LD0/LD1 with daddr 0x100 then 0x104; dhit with dmemload=0xAAAA0000; a following LW 0x104 hits next cycle with 0xBBBB0001.
REQ-046 SW 0x100=0x12345678, then LW 0x140 (same index 0) -> dWEN at daddr 0x100 (0x12345678) then 0x104, then dREN at 0x140 and 0x144.
REQ-047 dwait held high 5 cycles in LD0 -> daddr, dREN and state stable; dhit stays 0 throughout.
REQ-048 Dirty frames 2 and 5 then halt -> exactly 4 dWEN transfers, frames 2 then 5, then flushed=1 held.
REQ-049 LLSC_EN: LL 0x200; SW 0x200; SC 0x200 -> dmemload=0, memory unchanged. Repeat with no intervening SW -> dmemload=1, word written.
REQ-050 nRST pulsed low during WB1 -> outputs at reset values immediately; next LW to the old address misses.
